seq_shift_unit: RTL
===================

// Module: seq_shift_unit
// PURPOSE
//   Parametrised multi-cycle shift/rotate unit with a start/done handshake.
//   Supersedes fixed-amount, fixed-direction constant shifters.
//   Supports run-time shift amount and four shift modes.
//   Shifts STEP bit positions per clock, trading latency for area.
//   Serves the execute stage for SLL/SRL/SRA/ROR-class instructions and their variable forms.
// PARAMETERS
//   WIDTH    32  operand/result width in bits (>=2)
//   SHAMT_W  5   shift-amount width; must equal $clog2(WIDTH)
//   STEP     4   max bit positions shifted per cycle; power of two, 1..WIDTH
// PORTS
//   clk       in   1        single clock, rising edge
//   reset     in   1        asynchronous, active-high reset
//   start     in   1        request; sampled only when ready (state IDLE or DONE)
//   op        in   2        00 SLL, 01 SRL, 10 SRA, 11 ROR (rotate right)
//   data_in   in   WIDTH    operand, captured on accepting edge
//   shamt     in   SHAMT_W  shift amount 0..WIDTH-1, captured on accepting edge
//   busy      out  1        high while state SHIFT
//   done      out  1        one-cycle pulse, high while state DONE
//   data_out  out  WIDTH    result register; holds last result until next completion
// BEHAVIOUR
// - Reset:
//   - state=IDLE; busy=0; done=0; data_out=0; internal work/rem/op registers=0.
//   - Reset asserted mid-operation aborts the operation immediately; no done is produced.
// - FSM states: IDLE, SHIFT, DONE.
// - Acceptance: on an edge E0 where start=1 and state is IDLE or DONE:
//   - capture work<=data_in, rem<=shamt, op_q<=op.
//   - next state = DONE if shamt==0 (data_out<=data_in); otherwise SHIFT.
// - SHIFT, each edge:
//   - s = min(STEP, rem).
//   - work <= work shifted by s per op_q:
//     - SLL: zero fill from the LSB side.
//     - SRL: zero fill from the MSB side.
//     - SRA: fill with work[WIDTH-1].
//     - ROR: bits leaving at the LSB re-enter at the MSB.
//   - rem <= rem - s.
//   - When rem - s == 0: data_out <= shifted work; state <= DONE.
// - Latency: k = ceil(shamt/STEP) SHIFT cycles.
//   - done is high in the cycle following edge E0+k (k=0 for shamt=0).
// - DONE lasts exactly one cycle:
//   - If start=1 in DONE, a new operation is accepted (back-to-back, no bubble).
//   - Otherwise state returns to IDLE.
// - start while busy=1 is ignored; inputs may change freely during SHIFT.
// - data_out changes only on entry to DONE; it is stable in IDLE and SHIFT.
// - shamt is unsigned; values >=WIDTH cannot be expressed when SHAMT_W=$clog2(WIDTH).
// - busy and done are never high simultaneously.
// - Per-cycle shift is by a registered amount; no combinational path from inputs to outputs.
// TESTING (WIDTH=32, STEP=4)
//   T1  SLL data_in=0x00000001 shamt=5 -> busy 2 cycles; done after E0+2; data_out=0x00000020
//   T2  SRA data_in=0x80000000 shamt=31 -> k=8; done after E0+8; data_out=0xFFFFFFFF;
//       SRL same operand -> data_out=0x00000001
//   T3  ROR data_in=0x12345678 shamt=8 -> k=2; data_out=0x78123456
//   T4  SRL data_in=0xDEADBEEF shamt=0 -> busy never high; done after E0; data_out=0xDEADBEEF
//   T5  start pulsed again during SHIFT with a new operand -> ignored, first result unchanged;
//       start held in DONE -> second op accepted, done pulses again after its k cycles
//   T6  reset asserted mid-SHIFT (T2 op, cycle 3) -> busy=0, done=0, data_out=0 immediately;
//       no later done pulse

Source files
------------

// File: rtl/seq_shift_unit_if.sv
// ----------------------------------------------------------------------------
// seq_shift_unit_if
//   Request/response bundle for the multi-cycle shift/rotate unit.
//   master : drives start/op/data_in/shamt, observes busy/done/data_out
//   slave  : the shift unit itself
// Signals
//   start     request, taken only while the unit is ready (IDLE or DONE)
//   op        00 SLL, 01 SRL, 10 SRA, 11 ROR
//   data_in   operand, WIDTH bits
//   shamt     shift amount, SHAMT_W bits, unsigned
//   busy      high while shifting
//   done      one-cycle completion pulse
//   data_out  last completed result
// ----------------------------------------------------------------------------
interface seq_shift_unit_if #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 5
) ();
  logic               start;
  logic [1:0]         op;
  logic [WIDTH-1:0]   data_in;
  logic [SHAMT_W-1:0] shamt;
  logic               busy;
  logic               done;
  logic [WIDTH-1:0]   data_out;

  modport master (
    output start, op, data_in, shamt,
    input  busy, done, data_out
  );

  modport slave (
    input  start, op, data_in, shamt,
    output busy, done, data_out
  );
endinterface

// File: rtl/seq_shift_unit.sv
// ----------------------------------------------------------------------------
// seq_shift_unit
//   Multi-cycle shift/rotate unit. An accepted request is shifted by at most
//   STEP bit positions per clock until the requested amount is exhausted, then
//   the result is registered on data_out and done pulses for one cycle.
//   Another request may be accepted in the DONE cycle (back-to-back).
// Parameters
//   WIDTH    operand/result width (>= 2)
//   SHAMT_W  shift-amount width, equal to $clog2(WIDTH)
//   STEP     max positions shifted per cycle, power of two, 1..WIDTH
//            (the interface instance must use the same WIDTH/SHAMT_W)
// Ports
//   clk      rising-edge clock
//   reset    asynchronous, active-high; aborts any operation in flight
//   bus      seq_shift_unit_if.slave request/response bundle
// ----------------------------------------------------------------------------
module seq_shift_unit #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 5,
  parameter int STEP    = 4
) (
  input  logic           clk,
  input  logic           reset,
  seq_shift_unit_if.slave bus
);

  typedef enum logic [1:0] {
    OP_SLL = 2'b00,
    OP_SRL = 2'b01,
    OP_SRA = 2'b10,
    OP_ROR = 2'b11
  } op_t;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01,
    DONE  = 2'b10
  } state_t;

  // One extra bit so that STEP and WIDTH themselves are representable.
  localparam int                AMT_W     = SHAMT_W + 1;
  localparam logic [AMT_W-1:0]  STEP_AMT  = AMT_W'(STEP);
  localparam logic [AMT_W-1:0]  WIDTH_AMT = AMT_W'(WIDTH);

  state_t             state, state_next;
  op_t                op_q;
  logic [WIDTH-1:0]   work;
  logic [WIDTH-1:0]   work_shifted;
  logic [WIDTH-1:0]   data_out_q;
  logic [SHAMT_W-1:0] rem;
  logic [SHAMT_W-1:0] rem_next;
  logic [AMT_W-1:0]   step_amt;
  logic               ready;
  logic               accept;
  logic               last_step;

  // Shift v by s positions (0 < s <= STEP) in the requested mode.
  function automatic logic [WIDTH-1:0] shift_by(
    input logic [WIDTH-1:0] v,
    input op_t              o,
    input logic [AMT_W-1:0] s
  );
    case (o)
      OP_SLL:  return v << s;
      OP_SRL:  return v >> s;
      OP_SRA:  return $signed(v) >>> s;
      default: return (v >> s) | (v << (WIDTH_AMT - s)); // OP_ROR
    endcase
  endfunction

  // This cycle's step: min(STEP, rem). Since rem <= WIDTH-1, step_amt never
  // exceeds rem and the subtraction cannot wrap.
  assign step_amt     = ({1'b0, rem} > STEP_AMT) ? STEP_AMT : {1'b0, rem};
  assign rem_next     = rem - step_amt[SHAMT_W-1:0];
  assign last_step    = (rem_next == '0);
  assign work_shifted = shift_by(work, op_q, step_amt);

  assign ready  = (state == IDLE) || (state == DONE);
  assign accept = bus.start && ready;

  // NOTE: sequential state is assigned with <= so every register samples the
  // pre-edge value of its sources, independent of block ordering.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // NOTE: state_next gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_next = state;
    case (state)
      IDLE, DONE: begin
        if (accept) state_next = (bus.shamt == '0) ? DONE : SHIFT;
        else        state_next = IDLE;
      end
      SHIFT: begin
        if (last_step) state_next = DONE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Datapath. accept and SHIFT are mutually exclusive, so the priority order
  // below never matters in practice.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      work       <= '0;
      rem        <= '0;
      op_q       <= OP_SLL;
      data_out_q <= '0;
    end else if (accept) begin
      work <= bus.data_in;
      rem  <= bus.shamt;
      op_q <= op_t'(bus.op);
      // Zero-amount requests complete on the accepting edge.
      if (bus.shamt == '0) data_out_q <= bus.data_in;
    end else if (state == SHIFT) begin
      work <= work_shifted;
      rem  <= rem_next;
      if (last_step) data_out_q <= work_shifted;
    end
  end

  // All outputs are decoded from registers only.
  assign bus.busy     = (state == SHIFT);
  assign bus.done     = (state == DONE);
  assign bus.data_out = data_out_q;

endmodule
